// File: rtl/uart_fifo_tx_mgr_pkg.sv
// Shared UART TX manager definitions: FSM state encoding and datapath widths.
// Consumed by uart_fifo_tx_mgr (optional GAP state enabled by UART_TX_GAP_EN).
package uart_fifo_tx_mgr_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned CYC_W  = 24;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_WAIT  = 3'd2,
      ST_START = 3'd3,
      ST_SEND  = 3'd4,
      ST_GAP   = 3'd5
   } tx_state_e;

endpackage

// File: rtl/uart_fifo_tx_mgr.sv
// TX FIFO -> UART transmitter manager: pops a byte, starts the transmitter, waits for done.
// Define UART_TX_GAP_EN to insert GAP_CYC idle cycles after every completed byte.
module uart_fifo_tx_mgr
   import uart_fifo_tx_mgr_pkg::*;
#(
   parameter int unsigned      RD_LAT  = 1,
   parameter logic [CYC_W-1:0] TMO_CYC = 24'd1_000_000,
   parameter int unsigned      GAP_CYC = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              En,
   input  logic              Empty_sig,
   output logic              RD_Req_sig,
   input  logic [BYTE_W-1:0] FIFO_RD_Dat,
   output logic [BYTE_W-1:0] Tx_Dat,
   output logic              TxStart,
   input  logic              TxDoneflg,
   input  logic              ErrClr,
   output logic              Busy,
   output logic              Err,
   output logic [CNT_W-1:0]  TxCnt
);

   localparam logic [CYC_W-1:0] LAT_LAST = CYC_W'(RD_LAT - 1);
   localparam logic [CYC_W-1:0] TMO_LAST = TMO_CYC - CYC_W'(1);
`ifdef UART_TX_GAP_EN
   localparam logic [CYC_W-1:0] GAP_LAST = CYC_W'(GAP_CYC - 1);
`else
   logic gap_cyc_unused;
   assign gap_cyc_unused = (GAP_CYC != 0);
`endif

   tx_state_e         state_q, state_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic              rd_req_d, start_d, busy_d, err_d;
   logic [BYTE_W-1:0] dat_d;
   logic [CNT_W-1:0]  cnt_d;

   // One counter serves read latency, done timeout and inter-byte gap; each state clears it on entry.
   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      rd_req_d = 1'b0;
      start_d  = 1'b0;
      dat_d    = Tx_Dat;
      cnt_d    = TxCnt;
      err_d    = Err & ~ErrClr;
      case (state_q)
         ST_IDLE: begin
            if (En && !Empty_sig) begin
               state_d  = ST_RD;
               rd_req_d = 1'b1;
            end
         end
         ST_RD: begin
            state_d = ST_WAIT;
            cyc_d   = '0;
         end
         ST_WAIT: begin
            cyc_d = cyc_q + CYC_W'(1);
            if (cyc_q == LAT_LAST) begin
               dat_d   = FIFO_RD_Dat;
               start_d = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            state_d = ST_SEND;
            cyc_d   = '0;
         end
         ST_SEND: begin
            cyc_d = cyc_q + CYC_W'(1);
            // Done takes priority over a timeout expiring in the same cycle.
            if (TxDoneflg) begin
               cnt_d = TxCnt + CNT_W'(1);
`ifdef UART_TX_GAP_EN
               state_d = ST_GAP;
               cyc_d   = '0;
`else
               state_d = ST_IDLE;
`endif
            end else if (cyc_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
`ifdef UART_TX_GAP_EN
         ST_GAP: begin
            cyc_d = cyc_q + CYC_W'(1);
            if (cyc_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         cyc_q      <= '0;
         RD_Req_sig <= 1'b0;
         TxStart    <= 1'b0;
         Tx_Dat     <= '0;
         Busy       <= 1'b0;
         Err        <= 1'b0;
         TxCnt      <= '0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         RD_Req_sig <= rd_req_d;
         TxStart    <= start_d;
         Tx_Dat     <= dat_d;
         Busy       <= busy_d;
         Err        <= err_d;
         TxCnt      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_fifo_tx_mgr.sv
// Directed bench for uart_fifo_tx_mgr: lane 0 uses RD_LAT=1, lane 1 uses RD_LAT=3.
// Expected bytes are queued when offered to the FIFO model and popped at TxStart.
module tb_uart_fifo_tx_mgr;

   localparam logic [23:0] TMO  = 24'd50;
   localparam int unsigned GAPC = 16;
`ifdef UART_TX_GAP_EN
   localparam int   GAP_EXTRA = GAPC;
   localparam logic GAP_BUSY  = 1'b1;
`else
   localparam int   GAP_EXTRA = 0;
   localparam logic GAP_BUSY  = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  en, empty, done, errclr;
   logic [1:0]  rd_req, tx_start, busy, err;
   logic [7:0]  rd_dat [2];
   logic [7:0]  tx_dat [2];
   logic [7:0]  head   [2];
   logic [15:0] tx_cnt [2];
   logic [15:0] cnt_exp[2];
   logic [2:0]  req_sr [2];
   logic [7:0]  sb_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;

   always #5 CLK = ~CLK;

   uart_fifo_tx_mgr #(.RD_LAT(1), .TMO_CYC(TMO), .GAP_CYC(GAPC)) dut0 (
      .CLK(CLK), .RST(RST), .En(en[0]), .Empty_sig(empty[0]), .RD_Req_sig(rd_req[0]),
      .FIFO_RD_Dat(rd_dat[0]), .Tx_Dat(tx_dat[0]), .TxStart(tx_start[0]),
      .TxDoneflg(done[0]), .ErrClr(errclr[0]), .Busy(busy[0]), .Err(err[0]), .TxCnt(tx_cnt[0]));

   uart_fifo_tx_mgr #(.RD_LAT(3), .TMO_CYC(TMO), .GAP_CYC(GAPC)) dut1 (
      .CLK(CLK), .RST(RST), .En(en[1]), .Empty_sig(empty[1]), .RD_Req_sig(rd_req[1]),
      .FIFO_RD_Dat(rd_dat[1]), .Tx_Dat(tx_dat[1]), .TxStart(tx_start[1]),
      .TxDoneflg(done[1]), .ErrClr(errclr[1]), .Busy(busy[1]), .Err(err[1]), .TxCnt(tx_cnt[1]));

   // FIFO model: data is valid only in the cycle RD_LAT after the read pulse, otherwise filler.
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         req_sr[0] <= '0;
         req_sr[1] <= '0;
      end else begin
         req_sr[0] <= {req_sr[0][1:0], rd_req[0]};
         req_sr[1] <= {req_sr[1][1:0], rd_req[1]};
      end
   end
   assign rd_dat[0] = req_sr[0][0] ? head[0] : 8'hEE;
   assign rd_dat[1] = req_sr[1][2] ? head[1] : 8'hEE;

   function automatic int lat(input int l);
      return (l == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string tag, input int l, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s lane%0d observed=%0h expected=%0h", tag, l, obs, exp);
      end
   endtask

   task automatic chk_reset_vals();
      for (int l = 0; l < 2; l++) begin
         chk("rst_rd_req", l, rd_req[l], 0);
         chk("rst_tx_start", l, tx_start[l], 0);
         chk("rst_busy", l, busy[l], 0);
         chk("rst_err", l, err[l], 0);
         chk("rst_tx_dat", l, tx_dat[l], 0);
         chk("rst_tx_cnt", l, tx_cnt[l], 0);
      end
   endtask

   task automatic wait_req(input int l, input logic [7:0] d, input int exp_wait);
      int w = 0;
      head[l] = d;
      sb_q.push_back(d);
      do begin
         @(negedge CLK);
         w++;
      end while (rd_req[l] !== 1'b1 && w < 200);
      chk("rd_req_seen", l, rd_req[l], 1);
      chk("rd_req_wait", l, w, exp_wait);
      chk("busy_rd", l, busy[l], 1);
   endtask

   task automatic to_start(input int l);
      logic [7:0] e;
      for (int k = 0; k < lat(l); k++) begin
         @(negedge CLK);
         chk("rd_req_pulse", l, rd_req[l], 0);
         chk("start_early", l, tx_start[l], 0);
      end
      @(negedge CLK);
      e = sb_q.pop_front();
      chk("tx_start", l, tx_start[l], 1);
      chk("tx_dat", l, tx_dat[l], e);
      @(negedge CLK);
      chk("start_pulse", l, tx_start[l], 0);
   endtask

   task automatic finish_done(input int l, input int send_cyc, input logic exp_busy);
      repeat (send_cyc - 1) @(negedge CLK);
      done[l] = 1'b1;
      @(negedge CLK);
      done[l] = 1'b0;
      cnt_exp[l]++;
      chk("tx_cnt_done", l, tx_cnt[l], cnt_exp[l]);
      chk("busy_after_done", l, busy[l], exp_busy);
   endtask

   task automatic settle();
      repeat (GAPC + 4) @(negedge CLK);
   endtask

   initial begin
      RST = 1'b1; en = '0; empty = '1; done = '0; errclr = '0;
      head[0] = 8'h00; head[1] = 8'h00;
      cnt_exp[0] = '0; cnt_exp[1] = '0;
      repeat (3) @(negedge CLK);
      chk_reset_vals();
      RST = 1'b0;
      @(negedge CLK);

      // done while idle is ignored
      done[0] = 1'b1;
      @(negedge CLK);
      done[0] = 1'b0;
      @(negedge CLK);
      chk("done_idle_cnt", 0, tx_cnt[0], 0);
      chk("done_idle_busy", 0, busy[0], 0);

      // single byte, RD_LAT=1
      en[0] = 1'b1; empty[0] = 1'b0;
      wait_req(0, 8'hA5, 1);
      empty[0] = 1'b1;
      to_start(0);
      finish_done(0, 5, GAP_BUSY);
      settle();
      chk("busy_idle", 0, busy[0], 0);

      // three back-to-back bytes
      empty[0] = 1'b0;
      wait_req(0, 8'h01, 1);
      to_start(0);
      finish_done(0, 3, GAP_BUSY);
      wait_req(0, 8'h02, 1 + GAP_EXTRA);
      to_start(0);
      finish_done(0, 7, GAP_BUSY);
      wait_req(0, 8'h03, 1 + GAP_EXTRA);
      empty[0] = 1'b1;
      to_start(0);
      finish_done(0, 4, GAP_BUSY);
      settle();

      // enabled but empty
      repeat (100) begin
         @(negedge CLK);
         chk("empty_rd_req", 0, rd_req[0], 0);
         chk("empty_start", 0, tx_start[0], 0);
         chk("empty_busy", 0, busy[0], 0);
      end

      // done in the very cycle the timeout expires
      empty[0] = 1'b0;
      wait_req(0, 8'h3C, 1);
      empty[0] = 1'b1;
      to_start(0);
      finish_done(0, 50, GAP_BUSY);
      chk("tmo_edge_err", 0, err[0], 0);
      settle();

      // timeout, sticky Err, ErrClr
      empty[0] = 1'b0;
      wait_req(0, 8'h5A, 1);
      empty[0] = 1'b1;
      to_start(0);
      repeat (49) @(negedge CLK);
      chk("tmo_busy_pre", 0, busy[0], 1);
      chk("tmo_err_pre", 0, err[0], 0);
      @(negedge CLK);
      chk("tmo_err", 0, err[0], 1);
      chk("tmo_busy", 0, busy[0], 0);
      chk("tmo_cnt", 0, tx_cnt[0], cnt_exp[0]);
      repeat (5) @(negedge CLK);
      chk("err_sticky", 0, err[0], 1);
      errclr[0] = 1'b1;
      @(negedge CLK);
      errclr[0] = 1'b0;
      chk("err_clr", 0, err[0], 0);

      // En dropped mid-byte: byte completes, no further pop
      empty[0] = 1'b0;
      wait_req(0, 8'hC3, 1);
      to_start(0);
      en[0] = 1'b0;
      finish_done(0, 6, GAP_BUSY);
      repeat (30) begin
         @(negedge CLK);
         chk("en_off_rd_req", 0, rd_req[0], 0);
      end
      chk("en_off_busy", 0, busy[0], 0);
      en[0] = 1'b1;
      wait_req(0, 8'h96, 1);
      empty[0] = 1'b1;
      to_start(0);
      finish_done(0, 2, GAP_BUSY);
      settle();

      // lane 1, RD_LAT=3
      en[1] = 1'b1; empty[1] = 1'b0;
      wait_req(1, 8'h11, 1);
      to_start(1);
      finish_done(1, 4, GAP_BUSY);
      wait_req(1, 8'h22, 1 + GAP_EXTRA);
      empty[1] = 1'b1;
      to_start(1);
      finish_done(1, 3, GAP_BUSY);
      settle();

      // timeout coinciding with ErrClr: set wins, then clear
      empty[1] = 1'b0;
      wait_req(1, 8'h77, 1);
      empty[1] = 1'b1;
      to_start(1);
      repeat (49) @(negedge CLK);
      errclr[1] = 1'b1;
      @(negedge CLK);
      chk("err_set_wins", 1, err[1], 1);
      chk("tmo_cnt", 1, tx_cnt[1], cnt_exp[1]);
      @(negedge CLK);
      errclr[1] = 1'b0;
      chk("err_clr_after", 1, err[1], 0);
      settle();

      // async reset during WAIT, then a fresh transfer
      empty[1] = 1'b0;
      wait_req(1, 8'h44, 1);
      @(negedge CLK);
      #2 RST = 1'b1;
      #1 chk_reset_vals();
      void'(sb_q.pop_front());
      cnt_exp[0] = '0; cnt_exp[1] = '0;
      @(negedge CLK);
      RST = 1'b0;
      wait_req(1, 8'h55, 1);
      empty[1] = 1'b1;
      to_start(1);
      finish_done(1, 2, GAP_BUSY);
      settle();
      chk("final_busy", 1, busy[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_fifo_tx_mgr.md
# uart_fifo_tx_mgr

Transmit-side manager between the TX FIFO and the UART transmitter. While enabled and the FIFO is non-empty, it pops one byte, hands it to the transmitter with a start pulse, and waits for the transmitter's done flag before popping again. It counts bytes sent and flags a stalled transmitter through a done-timeout. It is the counterpart of the RX FIFO manager, so each UART channel has one FIFO-backed manager per direction.

## Interface
- RD_LAT, 1: FIFO read latency in cycles from RD_Req_sig to valid FIFO_RD_Dat; legal 1..3.
- TMO_CYC, 24'd1_000_000: cycles allowed in SEND before timeout; legal ≥ 2.
- GAP_CYC, 16: idle cycles between bytes; used only with the gap feature.

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- En  in  1  manager enable; sampled only in IDLE.
- Empty_sig  in  1  FIFO empty flag.
- RD_Req_sig  out  1  one-cycle FIFO read pulse; reset 0.
- FIFO_RD_Dat  in  8  FIFO read data.
- Tx_Dat  out  8  byte to transmitter; held until next load; reset 8'h00.
- TxStart  out  1  one-cycle transmit start pulse; reset 0.
- TxDoneflg  in  1  transmitter done pulse at end of stop bit.
- ErrClr  in  1  clears Err.
- Busy  out  1  high in any state except IDLE; reset 0.
- Err  out  1  sticky done-timeout flag; reset 0.
- TxCnt  out  16  bytes completed, wraps 16'hFFFF→0; reset 0.

## Operation
- Registered FSM with six states: IDLE, RD, WAIT, START, SEND, GAP. All outputs are registered.
- IDLE → RD when En=1 and Empty_sig=0.
- RD drives RD_Req_sig=1 for exactly one cycle, then → WAIT. The latency counter is cleared.
- WAIT counts RD_LAT cycles. At the last one it captures FIFO_RD_Dat into Tx_Dat, then → START.
- START drives TxStart=1 for exactly one cycle, then → SEND. The timeout counter is cleared.
- SEND on TxDoneflg=1: TxCnt+1. Goes → GAP if the gap feature is compiled in, otherwise → IDLE.
- SEND timeout: if the counter reaches TMO_CYC with no done, Err←1 and → IDLE. TxCnt is not incremented.
- GAP counts GAP_CYC cycles, then → IDLE.
- Boundaries:
  - RD_Req_sig is never asserted while Empty_sig=1 is being sampled in IDLE.
  - Empty_sig and En are ignored outside IDLE. Dropping En mid-byte lets that byte finish.
  - TxDoneflg is ignored outside SEND.
  - If done arrives in the same cycle the timeout expires, done wins.
  - ErrClr=1 clears Err. If a timeout sets Err in the same cycle, the set wins.
  - RST mid-operation returns every output to its reset value. A byte already in the transmitter is abandoned; the popped FIFO byte is lost.

## Timing
- Cycle N: IDLE samples En=1, Empty_sig=0.
- Cycle N+1: RD_Req_sig=1.
- FIFO_RD_Dat valid in cycle N+1+RD_LAT. It is captured at the end of that cycle.
- Cycle N+2+RD_LAT: Tx_Dat valid and TxStart=1, in the same cycle.
- TxDoneflg in cycle M: TxCnt updates in M+1. State is IDLE (or GAP) in M+1.
- Next pop: RD_Req_sig no earlier than M+2 without the gap feature, or M+2+GAP_CYC with it.
- Max throughput: one byte per transmitter frame plus RD_LAT+3 cycles.

## Configuration
- UART_TX_GAP_EN
  - Defined: the GAP state exists, and GAP_CYC idle cycles are inserted after every completed byte.
  - Undefined: the GAP state and its counter are removed. SEND goes straight to IDLE, and GAP_CYC is ignored.

## Structure
- The shared UART package holds:
  - state encoding constants: IDLE=3'd0, RD=1, WAIT=2, START=3, SEND=4, GAP=5;
  - byte width 8;
  - TxCnt width 16.
- No sub-module is needed. The timeout counter is a small inline counter. A generic cycle counter, uart_cyc_cnt, is reasonable if it is shared with the GAP counter.

## Test plan
- RD_LAT=1, FIFO holds 8'hA5, En=1 → RD_Req_sig one cycle at N+1; TxStart with Tx_Dat=8'hA5 at N+3; TxDoneflg → TxCnt=1, Busy=0.
- Three bytes 8'h01,8'h02,8'h03 with UART_TX_GAP_EN, GAP_CYC=16 → three pops in order, each RD_Req_sig ≥18 cycles after the previous TxDoneflg; TxCnt=3.
- Empty_sig=1 with En=1 for 100 cycles → RD_Req_sig and TxStart stay 0; Busy=0.
- TMO_CYC=50, TxDoneflg withheld → Err=1 after 50 SEND cycles, return to IDLE, TxCnt unchanged; ErrClr pulse → Err=0.
- En dropped during SEND, then TxDoneflg → byte completes, TxCnt+1, no further RD_Req_sig while En=0 despite Empty_sig=0.
- RST asserted during WAIT with RD_LAT=3 → all outputs at reset values immediately. After release with FIFO non-empty, a fresh RD → START sequence occurs.
